input_conditioner: RTL

- Upstream front end for the DE1_SoC top level. It conditions the raw board switches and pushbuttons before they reach the full-adder datapath and any later stages.
- Every switch and key passes through a two-flop synchronizer and then a per-bit debounce counter.
- Outputs: clean switch levels, active-high key levels, and single-cycle press/release/change pulses, all in the clk domain.

---
 rtl/de1_io_pkg.sv | 14 +
 rtl/debounce_bit.sv | 58 +++++
 rtl/input_conditioner.sv | 58 +++++
 3 files changed

// File: rtl/de1_io_pkg.sv
// rtl/de1_io_pkg.sv - shared constants and helpers for the DE1_SoC input front end
package de1_io_pkg;

  localparam int N_SW_DEFAULT  = 10;
  localparam int N_KEY_DEFAULT = 4;
  localparam int DEBOUNCE_SIM  = 4;
  localparam int DEBOUNCE_HW   = 500000;

  // Counter width able to hold 0..cycles without wrapping
  function automatic int debounce_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchronizer, debounce counter and edge flags for one input bit
module debounce_bit
  import de1_io_pkg::*;
#(
  parameter logic RESET_VAL       = 1'b0,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int            CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Plain two-flop synchronizer; reset to the idle level so no false edge appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // edge flags are set on the same edge as clean so they line up with the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronizes and debounces DE1_SoC switches and pushbuttons
module input_conditioner
  import de1_io_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int N_KEY           = N_KEY_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic             sw_changed,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release
);

  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;
  logic [N_KEY-1:0] key_db;

  // Switches idle low
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .RESET_VAL       (1'b0),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_raw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  // Keys idle high (active-low buttons): a falling debounced level is a press
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .RESET_VAL       (1'b1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (key_raw[i]),
      .clean (key_db[i]),
      .rise  (key_release[i]),
      .fall  (key_press[i])
    );
  end

  // Inversion of a flop output only, so key_level stays glitch-free and reads 0 in reset
  assign key_level  = ~key_db;
  assign sw_changed = |(sw_rise | sw_fall);

endmodule
